lcd_cmd_issuer: RTL and testbench

LCD_CMD_ISSUER -- requirements
Module: lcd_cmd_issuer

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_cmd_fifo.sv | 60 ++++++
 rtl/lcd_cmd_issuer.sv | 130 +++++++++++++
 tb/tb_lcd_cmd_issuer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types for the LCD command path: opcode set, command word and issuer FSM states.
package lcd_pkg;

    typedef logic [3:0] lcd_cmd_t;

    typedef enum logic [3:0] {
        OpWrite      = 4'h0,
        OpShiftUp    = 4'h1,
        OpShiftDown  = 4'h2,
        OpShiftLeft  = 4'h3,
        OpShiftRight = 4'h4,
        OpMax        = 4'h5,
        OpMin        = 4'h6,
        OpAvg        = 4'h7,
        OpRotCcw     = 4'h8,
        OpRotCw      = 4'h9,
        OpMirrorX    = 4'hA,
        OpMirrorY    = 4'hB
    } lcd_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitFree,
        StWaitDone,
        StFinish
    } lcd_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO between the host and the issuer FSM; power-of-two depth so the pointers wrap
// naturally and the occupancy count is kept separately to distinguish full from empty.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  lcd_cmd_t                 i_data,
    input  logic                     i_pop,
    output lcd_cmd_t                 o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    lcd_cmd_t          r_mem [DEPTH];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [LvlW-1:0]   r_level;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_level == LvlW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + LvlW'(w_push) - LvlW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Queues host opcodes and issues them one at a time to the LCD controller, pacing on its
// busy handshake; a Write followed by done ends the session until reset.
module lcd_cmd_issuer
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               issued_cnt,
    output logic                     finished
);

    localparam int unsigned ToW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    lcd_state_e      r_state;
    lcd_state_e      w_state_d;
    logic [ToW-1:0]  r_to_cnt;
    logic [ToW-1:0]  w_to_cnt_d;
    lcd_cmd_t        r_cmd;
    logic            r_cmd_valid;
    logic [7:0]      r_issued;
    logic            r_finished;

    logic            w_fifo_full;
    logic            w_fifo_empty;
    lcd_cmd_t        w_fifo_head;
    logic            w_push;
    logic            w_pop;

    assign host_ready = !w_fifo_full && !r_finished;
    assign w_push     = host_valid && host_ready;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (host_cmd),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    always_comb begin
        w_state_d  = r_state;
        w_pop      = 1'b0;
        w_to_cnt_d = '0;
        unique case (r_state)
            StIdle: begin
                if (!w_fifo_empty && !busy) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                w_pop     = 1'b1;
                w_state_d = (w_fifo_head == OpWrite) ? StWaitDone : StWaitBusy;
            end
            StWaitBusy: begin
                // A controller that never raises busy is treated as having consumed the command.
                if (busy) begin
                    w_state_d = StWaitFree;
                end else if (r_to_cnt == ToW'(BUSY_TIMEOUT - 1)) begin
                    w_state_d = StIdle;
                end else begin
                    w_to_cnt_d = r_to_cnt + 1'b1;
                end
            end
            StWaitFree: begin
                if (!busy) begin
                    w_state_d = StIdle;
                end
            end
            StWaitDone: begin
                if (done) begin
                    w_state_d = StFinish;
                end
            end
            StFinish: begin
                w_state_d = StFinish;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Strobe and opcode are loaded on entry to ISSUE so both leave straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_to_cnt    <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_issued    <= '0;
            r_finished  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_to_cnt    <= w_to_cnt_d;
            r_cmd_valid <= (w_state_d == StIssue);
            if (w_state_d == StIssue) begin
                r_cmd <= w_fifo_head;
            end
            if (r_state == StIssue && r_issued != 8'hFF) begin
                r_issued <= r_issued + 8'd1;
            end
            if (w_state_d == StFinish) begin
                r_finished <= 1'b1;
            end
        end
    end

    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign issued_cnt = r_issued;
    assign finished   = r_finished;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed bench for lcd_cmd_issuer: checks reset, issue ordering, FIFO limits, busy timeout,
// finish behaviour, mid-operation reset and counter saturation.
module tb_lcd_cmd_issuer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  host_cmd = 4'h0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic [3:0]  fifo_level;
    logic [7:0]  issued_cnt;
    logic        finished;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    lcd_cmd_issuer #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level),
        .issued_cnt (issued_cnt),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) strobe_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        host_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        reset      = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic push(input logic [3:0] c);
        host_cmd   = c;
        host_valid = 1'b1;
        step(1);
        host_valid = 1'b0;
    endtask

    task automatic wait_strobe(input int bound, output int cycles);
        cycles = 0;
        while (!cmd_valid && cycles < bound) begin
            step(1);
            cycles++;
        end
        check("strobe_seen", 32'(cmd_valid), 32'd1);
    endtask

    initial begin
        int cyc;
        int s;
        int pushed;
        int iter;

        // Power-on reset with a real falling edge.
        reset = 1'b1;
        #2 reset = 1'b0;
        step(2);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_issued", 32'(issued_cnt), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        reset = 1'b1;
        step(1);
        check("rst_host_ready", 32'(host_ready), 32'd1);

        // Queue 3,5,0 while the controller is busy.
        busy = 1'b1;
        push(4'h3);
        push(4'h5);
        push(4'h0);
        check("q3_level", 32'(fifo_level), 32'd3);
        check("q3_no_strobe", 32'(strobe_cnt), 32'd0);

        busy = 1'b0;
        wait_strobe(10, cyc);
        check("first_cmd", 32'(cmd), 32'd3);
        busy = 1'b1;
        step(2);
        check("cmd_hold", 32'(cmd), 32'd3);
        busy = 1'b0;
        wait_strobe(10, cyc);
        check("second_cmd", 32'(cmd), 32'd5);
        check("second_latency", 32'(cyc), 32'd2);
        busy = 1'b1;
        step(2);
        busy = 1'b0;
        wait_strobe(10, cyc);
        check("third_cmd", 32'(cmd), 32'd0);
        step(1);
        push(4'h7);
        check("wait_done_issued", 32'(issued_cnt), 32'd3);
        check("wait_done_not_finished", 32'(finished), 32'd0);
        check("wait_done_level", 32'(fifo_level), 32'd1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        check("finished_set", 32'(finished), 32'd1);
        step(3);
        check("finish_no_issue", 32'(strobe_cnt), 32'd3);
        check("finish_level_hold", 32'(fifo_level), 32'd1);

        // Pushes are refused once finished.
        host_cmd   = 4'h2;
        host_valid = 1'b1;
        check("finish_host_ready", 32'(host_ready), 32'd0);
        step(2);
        host_valid = 1'b0;
        check("finish_push_level", 32'(fifo_level), 32'd1);
        check("finish_push_strobes", 32'(strobe_cnt), 32'd3);
        check("finish_issued", 32'(issued_cnt), 32'd3);
        check("finish_cmd_hold", 32'(cmd), 32'd0);

        // Fill beyond depth while busy.
        do_reset();
        check("post_reset_finished", 32'(finished), 32'd0);
        busy = 1'b1;
        for (int i = 0; i < 8; i++) push(4'h1);
        check("full_level", 32'(fifo_level), 32'd8);
        host_cmd   = 4'h1;
        host_valid = 1'b1;
        check("full_host_ready", 32'(host_ready), 32'd0);
        step(1);
        host_valid = 1'b0;
        check("full_level_hold", 32'(fifo_level), 32'd8);

        // Reset while waiting for busy to fall with 7 queued.
        busy = 1'b0;
        wait_strobe(10, cyc);
        check("pre_reset_cmd", 32'(cmd), 32'd1);
        busy = 1'b1;
        step(2);
        check("pre_reset_level", 32'(fifo_level), 32'd7);
        check("pre_reset_issued", 32'(issued_cnt), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_cmd", 32'(cmd), 32'd0);
        check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_issued", 32'(issued_cnt), 32'd0);
        check("mid_rst_finished", 32'(finished), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        s    = strobe_cnt;
        busy = 1'b0;
        step(3);
        check("in_rst_no_strobe", 32'(strobe_cnt), 32'(s));
        reset = 1'b1;
        step(1);
        check("rel_no_strobe", 32'(strobe_cnt), 32'(s));
        check("rel_host_ready", 32'(host_ready), 32'd1);
        check("rel_level", 32'(fifo_level), 32'd0);

        // Busy never rises: four-cycle timeout, then the next command issues.
        host_cmd   = 4'h1;
        host_valid = 1'b1;
        step(1);
        host_cmd = 4'h2;
        step(1);
        host_valid = 1'b0;
        wait_strobe(10, cyc);
        check("to_first_cmd", 32'(cmd), 32'd1);
        step(1);
        wait_strobe(12, cyc);
        check("to_second_cmd", 32'(cmd), 32'd2);
        check("to_gap", 32'(cyc), 32'd5);
        step(1);
        check("to_issued", 32'(issued_cnt), 32'd2);

        // 300 non-Write commands saturate the issue counter.
        do_reset();
        s      = strobe_cnt;
        pushed = 0;
        iter   = 0;
        host_valid = 1'b1;
        while (pushed < 300 && iter < 5000) begin
            host_cmd = 4'((pushed % 11) + 1);
            if (host_ready) pushed++;
            step(1);
            iter++;
        end
        host_valid = 1'b0;
        check("sat_all_pushed", 32'(pushed), 32'd300);
        iter = 0;
        while (fifo_level != 4'd0 && iter < 200) begin
            step(1);
            iter++;
        end
        step(10);
        check("sat_strobes", 32'(strobe_cnt - s), 32'd300);
        check("sat_issued", 32'(issued_cnt), 32'd255);
        check("sat_level", 32'(fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
